mac_rx_deframer: RTL and testbench

//  Parametrised successor to the nibble-wide MAC receive path. Samples a 4-bit PHY data stream
//  (already in the MAC clock domain) and strips the preamble/SFD. Packs payload nibbles into

---
 rtl/mac_rx_deframer.sv | 176 +++++++++++++++++
 tb/tb_mac_rx_deframer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_deframer.sv
// Nibble-wide MAC receive deframer: strips preamble/SFD, packs payload into little-endian
// DATA_W words, applies length and DA checks, and keeps saturating frame statistics.
module mac_rx_deframer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PRE_MIN = 8,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                config_ready,
  input  logic                phy_rx_ctl,
  input  logic [3:0]          phy_rxd,
  input  logic [47:0]         mac_addr,
  input  logic                promisc,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_keep,
  output logic                out_valid,
  output logic                out_last,
  output logic [3:0]          out_status,
  output logic [CNT_W-1:0]    frame_ok_cnt,
  output logic [CNT_W-1:0]    frame_err_cnt
);
  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP} state_e;
  state_e state_q, state_d;

  logic [7:0]        pre_cnt;
  logic              nib_half;
  logic [3:0]        nib_lo;
  logic [DATA_W-1:0] word, word_ins;
  logic              full;
  logic [15:0]       byte_cnt;
  logic              da_mac, da_bc;
  logic [LW-1:0]     lane;
  logic [7:0]        rx_byte;
  logic [63:0]       mac_ext;
  logic [LANES-1:0]  keep_part;
  logic [3:0]        status_end;
  logic              start_pre, inc_pre, enter_data, take_nib, emit, emit_last, ovf;

  assign lane    = LW'(byte_cnt % 16'(LANES));
  assign rx_byte = {phy_rxd, nib_lo};
  assign mac_ext = {16'h0000, mac_addr};

  // Writing lane 0 starts a fresh word so unfilled lanes of a short last beat read as zero.
  always_comb begin
    word_ins = (lane == '0) ? '0 : word;
    word_ins[8*lane +: 8] = rx_byte;
  end

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) keep_part[i] = (i < 32'(lane));
  end

  always_comb begin
    status_end[0] = (byte_cnt < 16'(MIN_LEN));
    status_end[1] = ovf;
    status_end[2] = nib_half;
    status_end[3] = !promisc && ((byte_cnt < 16'd6) || !(da_mac || da_bc));
  end

  always_comb begin
    state_d    = state_q;
    start_pre  = 1'b0;
    inc_pre    = 1'b0;
    enter_data = 1'b0;
    take_nib   = 1'b0;
    emit       = 1'b0;
    emit_last  = 1'b0;
    ovf        = 1'b0;
    case (state_q)
      WAIT_IDLE: if (!phy_rx_ctl) state_d = IDLE;
      IDLE: begin
        if (phy_rx_ctl && config_ready) begin
          state_d   = PREAMBLE;
          start_pre = 1'b1;
        end
      end
      PREAMBLE: begin
        if (!phy_rx_ctl) state_d = IDLE;
        else if (phy_rxd == 4'h5) inc_pre = 1'b1;
        else if (phy_rxd == 4'hD && pre_cnt >= 8'(PRE_MIN - 1)) begin
          state_d    = DATA;
          enter_data = 1'b1;
        end else state_d = DROP;
      end
      DATA: begin
        if (!phy_rx_ctl) begin
          emit      = 1'b1;
          emit_last = 1'b1;
          state_d   = IDLE;
        end else if (!nib_half && byte_cnt == 16'(MAX_LEN)) begin
          // The held/partial word closes the frame instead of taking byte MAX_LEN+1.
          emit      = 1'b1;
          emit_last = 1'b1;
          ovf       = 1'b1;
          state_d   = DROP;
        end else begin
          take_nib = 1'b1;
          emit     = full;
        end
      end
      DROP: if (!phy_rx_ctl) state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data      <= '0;
      out_keep      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_status    <= '0;
      frame_ok_cnt  <= '0;
      frame_err_cnt <= '0;
      pre_cnt       <= '0;
      nib_half      <= 1'b0;
      nib_lo        <= '0;
      word          <= '0;
      full          <= 1'b0;
      byte_cnt      <= '0;
      da_mac        <= 1'b0;
      da_bc         <= 1'b0;
    end else begin
      out_valid <= emit;
      out_last  <= emit_last;
      if (emit) begin
        out_data   <= word;
        out_keep   <= (emit_last && !full) ? keep_part : '1;
        out_status <= emit_last ? status_end : '0;
      end
      if (emit_last) begin
        if (status_end == '0) begin
          if (frame_ok_cnt != '1) frame_ok_cnt <= frame_ok_cnt + 1'b1;
        end else begin
          if (frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + 1'b1;
        end
      end
      if (start_pre) pre_cnt <= (phy_rxd == 4'h5) ? 8'd1 : 8'd0;
      else if (inc_pre && pre_cnt != '1) pre_cnt <= pre_cnt + 8'd1;
      if (enter_data) begin
        nib_half <= 1'b0;
        full     <= 1'b0;
        byte_cnt <= '0;
        word     <= '0;
        da_mac   <= 1'b1;
        da_bc    <= 1'b1;
      end else if (take_nib) begin
        if (emit) full <= 1'b0;
        if (!nib_half) begin
          nib_lo   <= phy_rxd;
          nib_half <= 1'b1;
        end else begin
          nib_half <= 1'b0;
          word     <= word_ins;
          if (lane == LW'(LANES - 1)) full <= 1'b1;
          if (byte_cnt != '1) byte_cnt <= byte_cnt + 16'd1;
          if (byte_cnt < 16'd6) begin
            da_mac <= da_mac && (rx_byte == mac_ext[8*byte_cnt[2:0] +: 8]);
            da_bc  <= da_bc && (rx_byte == 8'hFF);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_rx_deframer.sv
// Table-driven bench for mac_rx_deframer with a beat scoreboard fed by a byte-level model.
module tb_mac_rx_deframer;
  localparam int unsigned DATA_W  = 32;
  localparam int          MAX_LEN = 1518;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        config_ready = 1'b1;
  logic        phy_rx_ctl = 1'b0;
  logic [3:0]  phy_rxd = 4'h0;
  logic [47:0] mac_addr = 48'h0605_0403_0201;
  logic        promisc = 1'b0;
  logic [DATA_W-1:0]   out_data;
  logic [DATA_W/8-1:0] out_keep;
  logic        out_valid, out_last;
  logic [3:0]  out_status;
  logic [15:0] frame_ok_cnt, frame_err_cnt;

  always #5 clk = ~clk;

  mac_rx_deframer #(.DATA_W(32), .PRE_MIN(8), .MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .config_ready(config_ready), .phy_rx_ctl(phy_rx_ctl),
    .phy_rxd(phy_rxd), .mac_addr(mac_addr), .promisc(promisc), .out_data(out_data),
    .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last), .out_status(out_status),
    .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  status;
  } beat_t;

  typedef struct {
    string      name;
    int         pre_n;
    int         da_kind;
    int         n;
    bit         extra;
    bit         prom;
    logic [3:0] st;
    int         beats;
  } vec_t;

  beat_t      sb[$];
  vec_t       vt[12];
  logic [7:0] fb[0:1599];
  int checks = 0, errors = 0, frame_beats = 0, exp_ok = 0, exp_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    beat_t       e;
    logic [31:0] mask;
    if (out_valid === 1'b1) begin
      frame_beats++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got beat data %0h keep %0h, expected no beat", out_data, out_keep);
      end else begin
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{e.keep[k]}};
        check("beat_keep", out_keep, e.keep);
        check("beat_data", out_data & mask, e.data);
        check("beat_last", out_last, e.last);
        if (e.last) check("beat_status", out_status, e.status);
      end
    end
  end

  task automatic drive(input logic c, input logic [3:0] d);
    @(negedge clk);
    phy_rx_ctl = c;
    phy_rxd    = d;
  endtask

  task automatic fill(input int n, input int da_kind);
    for (int i = 0; i < n; i++) begin
      if (i < 6) fb[i] = (da_kind == 0) ? 8'(i + 1) : (da_kind == 1) ? 8'hFF : 8'(8'h0A + i);
      else       fb[i] = 8'(i * 7 + 3);
    end
  endtask

  task automatic push_model(input int n, input logic [3:0] st);
    int    stored, nw, idx;
    beat_t b;
    stored = (n > MAX_LEN) ? MAX_LEN : n;
    nw     = (stored == 0) ? 1 : (stored + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      b.data = '0;
      b.keep = '0;
      for (int k = 0; k < 4; k++) begin
        idx = w * 4 + k;
        if (idx < stored) begin
          b.data[8*k +: 8] = fb[idx];
          b.keep[k] = 1'b1;
        end
      end
      b.last   = (w == nw - 1);
      b.status = b.last ? st : 4'h0;
      sb.push_back(b);
    end
  endtask

  task automatic send_bytes(input int from, input int to);
    for (int i = from; i < to; i++) begin
      drive(1'b1, fb[i][3:0]);
      drive(1'b1, fb[i][7:4]);
    end
  endtask

  task automatic check_counters(input string name);
    check({name, "_ok_cnt"}, frame_ok_cnt, exp_ok);
    check({name, "_err_cnt"}, frame_err_cnt, exp_err);
  endtask

  task automatic send_frame(input string name, input int pre_n, input int da_kind, input int n,
                            input bit extra, input bit prom, input logic [3:0] st, input int beats);
    promisc = prom;
    fill(n, da_kind);
    if (beats > 0) push_model(n, st);
    frame_beats = 0;
    for (int i = 0; i < pre_n; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    send_bytes(0, n);
    if (extra) drive(1'b1, 4'hA);
    repeat (5) drive(1'b0, 4'h0);
    #1;
    check({name, "_beats"}, frame_beats, beats);
    check({name, "_sb_drained"}, sb.size(), 0);
    if (beats > 0) begin
      if (st == 4'h0) exp_ok++;
      else            exp_err++;
    end
    check_counters(name);
  endtask

  initial begin
    vt[0]  = '{"good64",    15, 0,   64, 1'b0, 1'b0, 4'h0,  16};
    vt[1]  = '{"odd65",     15, 0,   65, 1'b1, 1'b0, 4'h4,  17};
    vt[2]  = '{"bcast60",   15, 1,   60, 1'b0, 1'b0, 4'h1,  15};
    vt[3]  = '{"damiss60",  15, 2,   60, 1'b0, 1'b0, 4'h9,  15};
    vt[4]  = '{"promisc60", 15, 2,   60, 1'b0, 1'b1, 4'h1,  15};
    vt[5]  = '{"minpre",     7, 0,   64, 1'b0, 1'b0, 4'h0,  16};
    vt[6]  = '{"shortpre",   6, 0,   64, 1'b0, 1'b0, 4'h0,   0};
    vt[7]  = '{"empty",     15, 0,    0, 1'b0, 1'b0, 4'h9,   1};
    vt[8]  = '{"short4",    15, 0,    4, 1'b0, 1'b0, 4'h9,   1};
    vt[9]  = '{"len63",     15, 0,   63, 1'b0, 1'b0, 4'h1,  16};
    vt[10] = '{"maxlen",    15, 0, 1518, 1'b0, 1'b0, 4'h0, 380};
    vt[11] = '{"oversize",  15, 0, 1600, 1'b0, 1'b0, 4'h2, 380};

    #1;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_keep", out_keep, 0);
    check("rst_status", out_status, 0);
    check_counters("rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) drive(1'b0, 4'h0);

    for (int i = 0; i < 12; i++)
      send_frame(vt[i].name, vt[i].pre_n, vt[i].da_kind, vt[i].n, vt[i].extra, vt[i].prom,
                 vt[i].st, vt[i].beats);

    // Bad preamble nibble, then a preamble cut short by phy_rx_ctl.
    promisc = 1'b0;
    fill(64, 0);
    frame_beats = 0;
    drive(1'b1, 4'h5); drive(1'b1, 4'h5); drive(1'b1, 4'h3);
    repeat (12) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    send_bytes(0, 64);
    repeat (3) drive(1'b0, 4'h0);
    repeat (6) drive(1'b1, 4'h5);
    repeat (5) drive(1'b0, 4'h0);
    #1;
    check("badpre_beats", frame_beats, 0);
    check_counters("badpre");

    // Frame arriving while config_ready is low is ignored.
    config_ready = 1'b0;
    send_frame("cfg_off", 15, 0, 64, 1'b0, 1'b0, 4'h0, 0);
    config_ready = 1'b1;

    // config_ready falling mid-frame lets the frame complete.
    fork
      send_frame("cfg_fall", 15, 0, 64, 1'b0, 1'b0, 4'h0, 16);
      begin
        repeat (60) @(negedge clk);
        config_ready = 1'b0;
      end
    join
    config_ready = 1'b1;

    // Reset after beat 5, released while phy_rx_ctl is still high.
    promisc = 1'b0;
    fill(64, 0);
    push_model(64, 4'h0);
    frame_beats = 0;
    repeat (15) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    send_bytes(0, 21);
    #1;
    check("rst_mid_beats_before", frame_beats, 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_last", out_last, 0);
    sb.delete();
    exp_ok  = 0;
    exp_err = 0;
    check_counters("rst_mid");
    send_bytes(21, 30);
    rst = 1'b0;
    frame_beats = 0;
    send_bytes(30, 64);
    repeat (5) drive(1'b0, 4'h0);
    #1;
    check("rst_mid_no_beats", frame_beats, 0);
    send_frame("after_rst", 15, 0, 64, 1'b0, 1'b0, 4'h0, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
